pt2262_tx_scheduler: RTL and testbench

Transmission scheduler that shares one `codificador_pt2262` encoder among `NUM_REQ` requesters. It arbitrates requests round-robin and latches the winner's address/data word onto the encoder inputs. It releases the encoder from reset, counts `REPEAT` complete code words by watching the encoder's `sync` output, then parks the encoder in reset again and reports completion or error to the winner. It sits between the application request logic and the encoder instance, in the same clock domain as the encoder (3 MHz `clk`).

---
 rtl/pt2262_tx_scheduler.sv | 154 +++++++++++++++
 tb/tb_pt2262_tx_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pt2262_tx_scheduler.sv
// Round-robin scheduler sharing one PT2262 encoder among NUM_REQ requesters.
// Latches the winner's A/D word, runs REPEAT words, then parks the encoder in reset.
module pt2262_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int REPEAT      = 4,
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_req_addr,
  input  logic [NUM_REQ*4-1:0] i_req_data,
  input  logic                 i_abort,
  input  logic                 i_enc_sync,
  output logic                 o_enc_rst,
  output logic [7:0]           o_enc_a,
  output logic [3:0]           o_enc_d,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [NUM_REQ-1:0]   o_done,
  output logic                 o_err,
  output logic                 o_busy,
  output logic [3:0]           o_frame_cnt
);

  localparam int LW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LW1 = LW + 1;
  localparam int TW  = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]      TMAX  = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]         REP   = 4'(REPEAT);
  localparam logic [LW-1:0]      LAST0 = LW'(NUM_REQ - 1);
  localparam logic [LW:0]        NR_W  = LW1'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [LW-1:0] r_last;
  logic [LW-1:0] r_owner;
  logic [TW-1:0] r_timer;
  logic          r_sync_q;

  logic          w_sync_rise;
  logic          w_any;
  logic [LW-1:0] w_win;
  logic [LW:0]   w_idx;

  assign w_sync_rise = i_enc_sync & ~r_sync_q;

  // Walk downward so the last hit is the nearest requester after r_last.
  always_comb begin
    w_any = 1'b0;
    w_win = LAST0;
    w_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = {1'b0, r_last} + LW1'(k);
      if (w_idx >= NR_W) begin
        w_idx = w_idx - NR_W;
      end else begin
        w_idx = w_idx;
      end
      if (i_req[w_idx[LW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[LW-1:0];
      end else begin
        w_any = w_any;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= LAST0;
      r_owner     <= '0;
      r_timer     <= '0;
      r_sync_q    <= 1'b0;
      o_enc_rst   <= 1'b1;
      o_enc_a     <= 8'h00;
      o_enc_d     <= 4'h0;
      o_grant     <= '0;
      o_done      <= '0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_cnt <= 4'd0;
    end else begin
      r_sync_q <= i_enc_sync;
      o_done   <= '0;
      o_err    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          o_enc_rst <= 1'b1;
          if (w_any) begin
            o_enc_a <= i_req_addr[{w_win, 3'b000} +: 8];
            o_enc_d <= i_req_data[{w_win, 2'b00} +: 4];
            o_grant <= ONE << w_win;
            r_owner <= w_win;
            o_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          o_frame_cnt <= 4'd0;
          r_timer     <= '0;
          o_enc_rst   <= 1'b0;
          r_state     <= S_RUN;
        end
        S_RUN: begin
          if (i_abort) begin
            // A coincident final sync still counts its word.
            o_frame_cnt <= o_frame_cnt + {3'b000, w_sync_rise};
            o_err       <= 1'b1;
            o_done      <= ONE << r_owner;
            o_grant     <= '0;
            o_enc_rst   <= 1'b1;
            r_last      <= r_owner;
            r_state     <= S_DONE;
          end else if (w_sync_rise) begin
            o_frame_cnt <= o_frame_cnt + 4'd1;
            r_timer     <= '0;
            if (o_frame_cnt + 4'd1 == REP) begin
              o_done    <= ONE << r_owner;
              o_grant   <= '0;
              o_enc_rst <= 1'b1;
              r_last    <= r_owner;
              r_state   <= S_DONE;
            end
          end else if (r_timer == TMAX) begin
            o_err     <= 1'b1;
            o_done    <= ONE << r_owner;
            o_grant   <= '0;
            o_enc_rst <= 1'b1;
            r_last    <= r_owner;
            r_state   <= S_DONE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_DONE: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Self-checking bench: encoder stub pulses sync every 200 cycles while released.
module tb_pt2262_tx_scheduler;
  localparam int NR  = 4;
  localparam int REP = 2;
  localparam int TO  = 300;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req = '0;
  logic [NR*8-1:0] req_addr = '0;
  logic [NR*4-1:0] req_data = '0;
  logic            abort = 1'b0;
  logic            enc_sync = 1'b0;
  logic            enc_rst;
  logic [7:0]      enc_a;
  logic [3:0]      enc_d;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic            err;
  logic            busy;
  logic [3:0]      frame_cnt;

  pt2262_tx_scheduler #(.NUM_REQ(NR), .REPEAT(REP), .TIMEOUT_CYC(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_req_addr(req_addr),
    .i_req_data(req_data), .i_abort(abort), .i_enc_sync(enc_sync),
    .o_enc_rst(enc_rst), .o_enc_a(enc_a), .o_enc_d(enc_d), .o_grant(grant),
    .o_done(done), .o_err(err), .o_busy(busy), .o_frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Encoder stub: 4-cycle sync pulse per 200 released cycles.
  int s_cnt = 0;
  bit stub_en = 1'b1;
  always @(posedge clk) begin
    if (enc_rst) begin
      s_cnt    <= 0;
      enc_sync <= 1'b0;
    end else begin
      s_cnt    <= (s_cnt == 199) ? 0 : s_cnt + 1;
      enc_sync <= stub_en && (s_cnt >= 195) && (s_cnt <= 198);
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] ta [NR];
  logic [3:0] td [NR];
  int m_last = NR - 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < NR; i++) begin
      req_addr[8*i +: 8] = ta[i];
      req_data[4*i +: 4] = td[i];
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int last);
    for (int k = 1; k <= NR; k++) begin
      if (r[(last + k) % NR]) return (last + k) % NR;
    end
    return -1;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_enc_rst"}, enc_rst, 1);
    check({tag, "_enc_a"}, enc_a, 0);
    check({tag, "_enc_d"}, enc_d, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  task automatic wait_grant(input int exp_cyc, input int owner);
    int n = 0;
    while (grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("grant_seen", {31'd0, grant != '0}, 1);
    check("grant_cycle", cyc, exp_cyc);
    check("grant_onehot", grant, 32'(1) << owner);
    check("enc_a_latch", enc_a, ta[owner]);
    check("enc_d_latch", enc_d, td[owner]);
    check("enc_rst_load", enc_rst, 1);
    check("busy_load", busy, 1);
  endtask

  // mode 0 normal, 1 timeout, 2 abort at +50, 3 abort with final sync
  task automatic observe(input int owner, input int mode);
    int rises = 0;
    int last_rise = -1;
    int abort_at = -1;
    int exp_cyc = 0;
    int t0;
    logic exp_err = 1'b0;
    int exp_fc = 0;
    bit prev;
    bit got = 1'b0;
    bit stable = 1'b1;
    logic [7:0] ea = ta[owner];
    logic [3:0] ed = td[owner];
    @(negedge clk);
    check("enc_rst_run", enc_rst, 0);
    t0 = cyc;
    prev = enc_sync;
    for (int n = 1; n <= 2000 && !got; n++) begin
      @(negedge clk);
      abort = 1'b0;
      if (done != '0) begin
        got = 1'b1;
        case (mode)
          0: begin exp_cyc = last_rise + 1;      exp_err = 1'b0; exp_fc = REP; end
          1: begin exp_cyc = last_rise + TO + 1; exp_err = 1'b1; exp_fc = 1;   end
          2: begin exp_cyc = abort_at + 1;       exp_err = 1'b1; exp_fc = rises; end
          default: begin exp_cyc = abort_at + 1; exp_err = 1'b1; exp_fc = REP; end
        endcase
        check("done_cycle", cyc, exp_cyc);
        check("done_owner", done, 32'(1) << owner);
        check("done_err", err, exp_err);
        check("done_frame_cnt", frame_cnt, exp_fc);
        check("done_enc_rst", enc_rst, 1);
        check("done_grant", grant, 0);
        check("done_busy", busy, 1);
        check("done_enc_a_hold", enc_a, ea);
        check("done_enc_d_hold", enc_d, ed);
        check("run_stable", stable, 1);
      end else begin
        stable &= (enc_a === ea) && (enc_d === ed) && (grant === (NR'(1) << owner))
                  && (enc_rst === 1'b0) && (busy === 1'b1);
        if (enc_sync && !prev) begin
          rises++;
          last_rise = cyc;
          if (mode == 1 && rises == 1) stub_en = 1'b0;
          if (mode == 3 && rises == REP) begin abort = 1'b1; abort_at = cyc; end
        end
        if (mode == 2 && cyc == t0 + 50) begin abort = 1'b1; abort_at = cyc; end
        if (mode == 0 && n == 30) begin
          ta[owner] = ~ta[owner];
          td[owner] = ~td[owner];
          drive_bus();
        end
      end
      prev = enc_sync;
    end
    check("done_seen", got, 1);
    @(negedge clk);
    check("after_done", done, 0);
    check("after_err", err, 0);
    check("after_busy", busy, 0);
    check("after_enc_rst", enc_rst, 1);
    stub_en = 1'b1;
    abort = 1'b0;
  endtask

  task automatic txn(input logic [NR-1:0] r, input int mode);
    int owner;
    req = r;
    owner = rr_pick(r, m_last);
    wait_grant(cyc + 1, owner);
    observe(owner, mode);
    m_last = owner;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      ta[i] = 8'($urandom);
      td[i] = 4'($urandom);
    end
    ta[0] = 8'hA5;
    td[0] = 4'h9;
    drive_bus();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_grant", grant, 0);
    check("idle_enc_rst", enc_rst, 1);

    // Single request, dropped during the transmission.
    req = 4'b0001;
    wait_grant(cyc + 1, 0);
    req = 4'b0000;
    observe(0, 0);
    m_last = 0;
    repeat (5) @(negedge clk);
    check("no_req_idle", busy, 0);

    // Round-robin with all requests held.
    for (int i = 0; i < NR; i++) begin
      ta[i] = 8'($urandom);
      td[i] = 4'($urandom);
    end
    drive_bus();
    for (int t = 0; t < 5; t++) txn(4'b1111, 0);

    // Randomised patterns and endings.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < NR; i++) begin
        ta[i] = 8'($urandom);
        td[i] = 4'($urandom);
      end
      drive_bus();
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end

    txn(4'b0100, 1);
    txn(4'b1000, 2);
    txn(4'b0001, 3);
    req = 4'b0000;
    repeat (3) @(negedge clk);

    // Reset in the middle of RUN.
    req = 4'b0100;
    wait_grant(cyc + 1, rr_pick(4'b0100, m_last));
    req = 4'b0000;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NR - 1;
    @(negedge clk);
    txn(4'b0010, 0);
    txn(4'b0011, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
